// File: rtl/compare_match_tracker.sv
// Best-of-ROUNDS scorer fed by a 4-bit magnitude comparator.
// Tallies A/B/tie rounds on each sample strobe and reports the match winner.
module compare_match_tracker #(
  parameter int ROUNDS = 5,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample,
  input  logic             equal,
  input  logic             a_greater,
  input  logic             b_greater,
  output logic [CNT_W-1:0] a_wins,
  output logic [CNT_W-1:0] b_wins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] round_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             illegal
);

  localparam logic [CNT_W-1:0] WIN_NEED = CNT_W'(ROUNDS / 2 + 1);
  localparam logic [CNT_W-1:0] ROUND_MAX = CNT_W'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_a_wins;
  logic [CNT_W-1:0] r_b_wins;
  logic [CNT_W-1:0] r_ties;
  logic [CNT_W-1:0] r_round_cnt;
  logic [1:0]       r_winner;
  logic             r_illegal;

  logic             w_onehot;
  logic             w_score;
  logic             w_legal;
  logic [CNT_W-1:0] w_a_nxt;
  logic [CNT_W-1:0] w_b_nxt;
  logic [CNT_W-1:0] w_t_nxt;
  logic [CNT_W-1:0] w_rnd_nxt;
  logic             w_decide;
  logic [1:0]       w_winner_nxt;

  always_comb begin
    w_onehot     = 1'b0;
    w_score      = 1'b0;
    w_legal      = 1'b0;
    w_a_nxt      = r_a_wins;
    w_b_nxt      = r_b_wins;
    w_t_nxt      = r_ties;
    w_rnd_nxt    = r_round_cnt;
    w_decide     = 1'b0;
    w_winner_nxt = 2'b11;

    case ({equal, a_greater, b_greater})
      3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
      default:                w_onehot = 1'b0;
    endcase

    // start always takes priority, so a coincident sample is dropped
    w_score = (r_state == S_PLAY) && sample && !start;
    w_legal = w_score && w_onehot;

    if (w_legal) begin
      w_a_nxt   = r_a_wins    + {{(CNT_W-1){1'b0}}, a_greater};
      w_b_nxt   = r_b_wins    + {{(CNT_W-1){1'b0}}, b_greater};
      w_t_nxt   = r_ties      + {{(CNT_W-1){1'b0}}, equal};
      w_rnd_nxt = r_round_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_rnd_nxt = r_round_cnt;
    end

    w_decide = w_legal &&
               ((w_a_nxt == WIN_NEED) || (w_b_nxt == WIN_NEED) || (w_rnd_nxt == ROUND_MAX));

    if (w_a_nxt > w_b_nxt) begin
      w_winner_nxt = 2'b01;
    end else if (w_b_nxt > w_a_nxt) begin
      w_winner_nxt = 2'b10;
    end else begin
      w_winner_nxt = 2'b11;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_PLAY;
        else       w_state_nxt = S_IDLE;
      end
      S_PLAY: begin
        if (start)         w_state_nxt = S_PLAY;
        else if (w_decide) w_state_nxt = S_FINISH;
        else               w_state_nxt = S_PLAY;
      end
      S_FINISH: begin
        if (start) w_state_nxt = S_PLAY;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_wins    <= '0;
      r_b_wins    <= '0;
      r_ties      <= '0;
      r_round_cnt <= '0;
      r_winner    <= 2'b00;
      r_illegal   <= 1'b0;
    end else if (start) begin
      r_a_wins    <= '0;
      r_b_wins    <= '0;
      r_ties      <= '0;
      r_round_cnt <= '0;
      r_winner    <= 2'b00;
      r_illegal   <= 1'b0;
    end else begin
      r_a_wins    <= w_a_nxt;
      r_b_wins    <= w_b_nxt;
      r_ties      <= w_t_nxt;
      r_round_cnt <= w_rnd_nxt;
      if (w_decide) begin
        r_winner <= w_winner_nxt;
      end
      if (w_score && !w_onehot) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign a_wins    = r_a_wins;
  assign b_wins    = r_b_wins;
  assign ties      = r_ties;
  assign round_cnt = r_round_cnt;
  assign winner    = r_winner;
  assign illegal   = r_illegal;
  assign busy      = (r_state == S_PLAY);
  assign done      = (r_state == S_FINISH);

endmodule

// File: tb/tb_compare_match_tracker.sv
// Self-checking bench for compare_match_tracker: directed scenarios plus
// randomized traffic, checked every cycle against an integer match model.
module tb_compare_match_tracker;

  localparam int ROUNDS = 5;
  localparam int CNT_W  = 4;
  localparam int NEED   = ROUNDS / 2 + 1;

  logic             clk;
  logic             clk_en;
  logic             rst;
  logic             start;
  logic             sample;
  logic             equal;
  logic             a_greater;
  logic             b_greater;
  logic [CNT_W-1:0] a_wins;
  logic [CNT_W-1:0] b_wins;
  logic [CNT_W-1:0] ties;
  logic [CNT_W-1:0] round_cnt;
  logic             busy;
  logic             done;
  logic [1:0]       winner;
  logic             illegal;

  int n_compared;
  int n_mismatched;

  // reference model state
  int m_a, m_b, m_t, m_r, m_win, m_ill, m_busy, m_done;

  compare_match_tracker #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sample    (sample),
    .equal     (equal),
    .a_greater (a_greater),
    .b_greater (b_greater),
    .a_wins    (a_wins),
    .b_wins    (b_wins),
    .ties      (ties),
    .round_cnt (round_cnt),
    .busy      (busy),
    .done      (done),
    .winner    (winner),
    .illegal   (illegal)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".a_wins"},    int'(a_wins),    m_a);
    check_val({tag, ".b_wins"},    int'(b_wins),    m_b);
    check_val({tag, ".ties"},      int'(ties),      m_t);
    check_val({tag, ".round_cnt"}, int'(round_cnt), m_r);
    check_val({tag, ".busy"},      int'(busy),      m_busy);
    check_val({tag, ".done"},      int'(done),      m_done);
    check_val({tag, ".winner"},    int'(winner),    m_win);
    check_val({tag, ".illegal"},   int'(illegal),   m_ill);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_t = 0; m_r = 0;
    m_win = 0; m_ill = 0; m_busy = 0; m_done = 0;
  endtask

  // One clock of match rules: start restarts, a scored sample in a live match
  // either tallies a round (and may end the match) or flags illegal.
  task automatic model_step(input logic st, input logic sm, input logic eq,
                            input logic ag, input logic bg);
    int n_flags;
    n_flags = int'(eq) + int'(ag) + int'(bg);
    m_done = 0;
    if (st) begin
      m_a = 0; m_b = 0; m_t = 0; m_r = 0; m_win = 0; m_ill = 0;
      m_busy = 1;
    end else if (m_busy == 1 && sm) begin
      if (n_flags == 1) begin
        if (ag) m_a++;
        else if (bg) m_b++;
        else m_t++;
        m_r++;
        if (m_a == NEED || m_b == NEED || m_r == ROUNDS) begin
          m_win  = (m_a > m_b) ? 1 : ((m_b > m_a) ? 2 : 3);
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        m_ill = 1;
      end
    end
  endtask

  task automatic tick(input string tag, input logic st, input logic sm,
                      input logic eq, input logic ag, input logic bg);
    start = st; sample = sm; equal = eq; a_greater = ag; b_greater = bg;
    @(posedge clk);
    model_step(st, sm, eq, ag, bg);
    #1;
    check_all(tag);
  endtask

  task automatic idle_tick(input string tag);
    tick(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic round_a(input string tag); tick(tag, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); endtask
  task automatic round_b(input string tag); tick(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic round_t(input string tag); tick(tag, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_start(input string tag); tick(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  // Reset between edges: outputs must clear without any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic st, sm, eq, ag, bg;
    logic [2:0] flags;
    int pick;

    n_compared = 0;
    n_mismatched = 0;
    clk = 1'b0; clk_en = 1'b0;
    rst = 1'b0; start = 1'b0; sample = 1'b0;
    equal = 1'b0; a_greater = 1'b0; b_greater = 1'b0;

    // 1: reset with no clock, then samples in IDLE are ignored
    #3 rst = 1'b1;
    #2;
    model_reset();
    check_all("rst_noclk");
    clk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    round_a("idle_samp_a");
    round_b("idle_samp_b");
    round_t("idle_samp_t");

    // 2: A takes three straight rounds, later samples ignored
    do_start("t2_start");
    round_a("t2_r1");
    round_a("t2_r2");
    round_a("t2_r3");
    idle_tick("t2_done");
    round_b("t2_late");

    // 3: A, B, tie, B, A -> draw after all rounds
    do_start("t3_start");
    round_a("t3_r1");
    round_b("t3_r2");
    round_t("t3_r3");
    round_b("t3_r4");
    round_a("t3_r5");
    idle_tick("t3_done");

    // 4: illegal flags do not score, sticky flag survives a legal round
    do_start("t4_start");
    tick("t4_illegal", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("t4_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    round_b("t4_legal");

    // 5: start coinciding with a sample restarts and drops the sample
    do_start("t5_start");
    round_a("t5_r1");
    round_a("t5_r2");
    tick("t5_restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    round_b("t5_b1");
    round_b("t5_b2");
    round_b("t5_b3");
    idle_tick("t5_done");

    // start during FINISH: done still shows, then a fresh match
    do_start("tf_start");
    round_b("tf_b1");
    round_b("tf_b2");
    round_b("tf_b3");
    do_start("tf_restart");
    idle_tick("tf_play");

    // 6: async reset mid-match with a_wins=2
    do_start("t6_start");
    round_a("t6_a1");
    round_a("t6_a2");
    async_reset("t6_rst");
    idle_tick("t6_after1");
    round_a("t6_after2");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 15) == 0);
      sm = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) begin
        flags = 3'($urandom_range(0, 7));
      end else begin
        pick  = int'($urandom_range(0, 2));
        flags = 3'(1 << pick);
      end
      eq = flags[2]; ag = flags[1]; bg = flags[0];
      tick("rand", st, sm, eq, ag, bg);
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
